// File: rtl/mk_xsim_top.sv
// Echo-service simulation shell: host request beats arrive through dpi_msgSink_beat and
// indication beats leave through dpi_msgSource_beat; only CLK and RST_N are pins.

// SystemVerilog stand-in for the host side of the message channel (request/indication queues).
package mk_xsim_host_pkg;
    logic [31:0] sink_q[$];
    logic [31:0] source_q[$];
    int unsigned sink_polls;
    int unsigned sink_portal;
    int unsigned source_portal;
    bit          stall_alt;
    bit          stall_phase;

    function automatic void dpi_msgSink_beat(input int unsigned portal, output logic [31:0] beat,
                                             output logic [31:0] src_rdy);
        sink_polls  = sink_polls + 1;
        sink_portal = portal;
        beat        = '0;
        src_rdy     = '0;
        if (stall_alt) stall_phase = !stall_phase;
        if (!(stall_alt && stall_phase) && sink_q.size() != 0) begin
            beat    = sink_q.pop_front();
            src_rdy = 32'd1;
        end
    endfunction

    function automatic void dpi_msgSource_beat(input int unsigned portal, input logic [31:0] beat);
        source_portal = portal;
        source_q.push_back(beat);
    endfunction
endpackage

module mk_xsim_top #(
    parameter int unsigned REQ_PORTAL = 0,
    parameter int unsigned IND_PORTAL = 1,
    parameter int unsigned MAX_WORDS  = 16
) (
    input logic CLK,
    input logic RST_N
);
    import mk_xsim_host_pkg::*;

    localparam int unsigned IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    typedef enum logic [1:0] {RX_HDR, RX_BODY, PROCESS, TX} state_t;

    state_t      state_q;
    logic [15:0] method_q;
    logic [15:0] len_q;
    logic [15:0] rx_cnt_q;
    logic [31:0] payload_q [MAX_WORDS];
    logic [31:0] req_count_q, req_count_d;
    logic [31:0] err_count_q, err_count_d;
    logic [31:0] ind_q [4];
    logic [31:0] ind_d [4];
    logic [1:0]  ind_len_q, ind_len_d;
    logic [1:0]  tx_idx_q;
    logic [31:0] word0, word1;

    // Payload words the message did not carry read as zero, independent of stale buffer contents.
    always_comb begin
        word0       = (rx_cnt_q > 16'd0) ? payload_q[0] : '0;
        word1       = (rx_cnt_q > 16'd1) ? payload_q[1] : '0;
        req_count_d = req_count_q + 32'd1;
        err_count_d = err_count_q;
        ind_d[0]    = '0;
        ind_d[1]    = '0;
        ind_d[2]    = '0;
        ind_d[3]    = '0;
        ind_len_d   = 2'd2;
        case (method_q)
            16'd0: begin
                ind_d[0] = {16'd0, 16'd2};
                ind_d[1] = word0;
            end
            16'd1: begin
                ind_d[0]  = {16'd1, 16'd3};
                ind_d[1]  = word0;
                ind_d[2]  = word1;
                ind_len_d = 2'd3;
            end
            16'd2: begin
                ind_d[0] = {16'd2, 16'd2};
                ind_d[1] = req_count_d;
            end
            default: begin
                err_count_d = err_count_q + 32'd1;
                ind_d[0]    = {16'd3, 16'd3};
                ind_d[1]    = {16'b0, method_q};
                ind_d[2]    = {16'b0, len_q};
                ind_len_d   = 2'd3;
            end
        endcase
    end

    always_ff @(posedge CLK) begin : seq
        logic [31:0] beat;
        logic [31:0] rdy;
        if (!RST_N) begin
            state_q     <= RX_HDR;
            method_q    <= '0;
            len_q       <= '0;
            rx_cnt_q    <= '0;
            req_count_q <= '0;
            err_count_q <= '0;
            ind_len_q   <= '0;
            tx_idx_q    <= '0;
            for (int unsigned i = 0; i < MAX_WORDS; i++) payload_q[i] <= '0;
            for (int unsigned i = 0; i < 4; i++) ind_q[i] <= '0;
        end else begin
            case (state_q)
                RX_HDR: begin
                    dpi_msgSink_beat(REQ_PORTAL, beat, rdy);
                    if (rdy != '0) begin
                        method_q <= beat[31:16];
                        len_q    <= (beat[15:0] == 16'd0) ? 16'd1 : beat[15:0];
                        rx_cnt_q <= '0;
                        state_q  <= (beat[15:0] <= 16'd1) ? PROCESS : RX_BODY;
                    end
                end
                RX_BODY: begin
                    dpi_msgSink_beat(REQ_PORTAL, beat, rdy);
                    if (rdy != '0) begin
                        if ({16'b0, rx_cnt_q} < MAX_WORDS) payload_q[rx_cnt_q[IW-1:0]] <= beat;
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                        if (rx_cnt_q + 16'd1 == len_q - 16'd1) state_q <= PROCESS;
                    end
                end
                PROCESS: begin
                    for (int unsigned i = 0; i < 4; i++) ind_q[i] <= ind_d[i];
                    ind_len_q   <= ind_len_d;
                    tx_idx_q    <= '0;
                    req_count_q <= req_count_d;
                    err_count_q <= err_count_d;
                    state_q     <= TX;
                end
                default: begin
                    dpi_msgSource_beat(IND_PORTAL, ind_q[tx_idx_q]);
                    tx_idx_q <= tx_idx_q + 2'd1;
                    if (tx_idx_q == ind_len_q - 2'd1) state_q <= RX_HDR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mk_xsim_top.sv
// Directed bench for the echo shell: drives the host queues and checks emitted indications.
module tb_mk_xsim_top;
    import mk_xsim_host_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mk_xsim_top #(.REQ_PORTAL(0), .IND_PORTAL(1), .MAX_WORDS(16)) dut (
        .CLK  (clk),
        .RST_N(rst_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_src(input int unsigned n, input int unsigned budget, output bit ok);
        int unsigned k = 0;
        while (source_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (source_q.size() >= n);
    endtask

    task automatic test_reset();
        logic [31:0] exp_q[$];
        bit ok;
        rst_n = 1'b0;
        sink_q = '{32'h0000_0002, 32'h1234_5678, 32'h0002_0001};
        repeat (20) tick();
        checks++;
        if (sink_polls !== 0) begin
            errors++;
            $display("FAIL reset_no_poll: polls %0d, required 0", sink_polls);
        end
        checks++;
        if (source_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_no_source: beats %0d, required 0", source_q.size());
        end
        rst_n = 1'b1;
        wait_src(4, 60, ok);
        repeat (4) tick();
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_timeout: beats %0d, required 4", source_q.size());
        end
        exp_q = '{32'h0000_0002, 32'h1234_5678, 32'h0002_0002, 32'h0000_0002};
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= source_q.size() || source_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL reset_beat%0d: got %h, required %h", i,
                         (i < source_q.size()) ? source_q[i] : 32'hxxxxxxxx, exp_q[i]);
            end
        end
        checks++;
        if (sink_portal !== 0 || source_portal !== 1) begin
            errors++;
            $display("FAIL portals: got %0d/%0d, required 0/1", sink_portal, source_portal);
        end
        source_q.delete();
    endtask

    task automatic test_say2();
        int unsigned last_take = 0, hdr = 0;
        logic [31:0] exp_q[$];
        sink_q = '{32'h0001_0003, 32'hAAAA_0001, 32'hBBBB_0002};
        for (int k = 0; k < 40 && source_q.size() < 3; k++) begin
            tick();
            if (last_take == 0 && sink_q.size() == 0) last_take = cyc;
            if (hdr == 0 && source_q.size() >= 1) hdr = cyc;
        end
        repeat (4) tick();
        checks++;
        if (hdr - last_take !== 2 || hdr == 0) begin
            errors++;
            $display("FAIL say2_latency: got %0d edges, required 2", hdr - last_take);
        end
        exp_q = '{32'h0001_0003, 32'hAAAA_0001, 32'hBBBB_0002};
        checks++;
        if (source_q.size() !== 3) begin
            errors++;
            $display("FAIL say2_count: got %0d, required 3", source_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= source_q.size() || source_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL say2_beat%0d: got %h, required %h", i,
                         (i < source_q.size()) ? source_q[i] : 32'hxxxxxxxx, exp_q[i]);
            end
        end
        source_q.delete();
    endtask

    task automatic test_stall();
        logic [31:0] exp_q[$];
        bit ok;
        stall_phase = 1'b0;
        stall_alt = 1'b1;
        sink_q = '{32'h0001_0003, 32'hAAAA_0001, 32'hBBBB_0002};
        wait_src(3, 60, ok);
        repeat (4) tick();
        stall_alt = 1'b0;
        checks++;
        if (!ok || source_q.size() !== 3) begin
            errors++;
            $display("FAIL stall_count: got %0d, required 3", source_q.size());
        end
        exp_q = '{32'h0001_0003, 32'hAAAA_0001, 32'hBBBB_0002};
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= source_q.size() || source_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stall_beat%0d: got %h, required %h", i,
                         (i < source_q.size()) ? source_q[i] : 32'hxxxxxxxx, exp_q[i]);
            end
        end
        source_q.delete();
    endtask

    task automatic test_unknown();
        logic [31:0] exp_q[$];
        bit ok;
        sink_q = '{32'h0007_0004, 32'h1, 32'h2, 32'h3, 32'h0000_0002, 32'hCAFE_F00D};
        wait_src(5, 80, ok);
        repeat (4) tick();
        checks++;
        if (!ok || source_q.size() !== 5) begin
            errors++;
            $display("FAIL unknown_count: got %0d, required 5", source_q.size());
        end
        exp_q = '{32'h0003_0003, 32'h0000_0007, 32'h0000_0004, 32'h0000_0002, 32'hCAFE_F00D};
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= source_q.size() || source_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL unknown_beat%0d: got %h, required %h", i,
                         (i < source_q.size()) ? source_q[i] : 32'hxxxxxxxx, exp_q[i]);
            end
        end
        source_q.delete();
    endtask

    // Oversize say, then a say2 missing its second word, then a ping with length field 0.
    task automatic test_oversize();
        logic [31:0] exp_q[$];
        bit ok;
        sink_q.push_back(32'h0000_0014);
        for (int i = 0; i < 19; i++) sink_q.push_back(32'h100 + i);
        sink_q.push_back(32'h0001_0002);
        sink_q.push_back(32'h5555_0001);
        sink_q.push_back(32'h0002_0000);
        wait_src(7, 120, ok);
        repeat (4) tick();
        checks++;
        if (!ok || source_q.size() !== 7 || sink_q.size() !== 0) begin
            errors++;
            $display("FAIL oversize_count: got %0d beats (%0d left), required 7 (0 left)",
                     source_q.size(), sink_q.size());
        end
        exp_q = '{32'h0000_0002, 32'h0000_0100, 32'h0001_0003, 32'h5555_0001, 32'h0,
                  32'h0002_0002, 32'h0000_0009};
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= source_q.size() || source_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL oversize_beat%0d: got %h, required %h", i,
                         (i < source_q.size()) ? source_q[i] : 32'hxxxxxxxx, exp_q[i]);
            end
        end
        source_q.delete();
    endtask

    task automatic test_reset_tx();
        bit ok;
        sink_q = '{32'h0001_0003, 32'hAAAA_0001, 32'hBBBB_0002};
        wait_src(1, 40, ok);
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (!ok || source_q.size() !== 1) begin
            errors++;
            $display("FAIL reset_tx_stop: got %0d beats, required 1", source_q.size());
        end
        source_q.delete();
        rst_n = 1'b1;
        sink_q = '{32'h0002_0001};
        wait_src(2, 40, ok);
        repeat (4) tick();
        checks++;
        if (!ok || source_q.size() !== 2) begin
            errors++;
            $display("FAIL reset_tx_count: got %0d, required 2", source_q.size());
        end
        checks++;
        if (source_q.size() < 2 || source_q[0] !== 32'h0002_0002 || source_q[1] !== 32'h0000_0001) begin
            errors++;
            $display("FAIL reset_tx_ping: got %h %h, required 00020002 00000001",
                     (source_q.size() > 0) ? source_q[0] : 32'hxxxxxxxx,
                     (source_q.size() > 1) ? source_q[1] : 32'hxxxxxxxx);
        end
        source_q.delete();
    endtask

    initial begin
        test_reset();
        test_say2();
        test_stall();
        test_unknown();
        test_oversize();
        test_reset_tx();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mk_xsim_top.md
Name: mk_xsim_top

Overview:
Top-level simulation shell under the xsim harness. It hosts one echo service exposed through the host message channel.
- It pulls 32-bit request beats from the host, one beat per clock, with the DPI call dpi_msgSink_beat.
- It decodes each request message and returns an indication message, one beat per clock, with the DPI call dpi_msgSource_beat.
- All host traffic passes through these two DPI calls. The only pins are the clock and the reset.

Parameters:
REQ_PORTAL, 0, portal number passed to dpi_msgSink_beat.
IND_PORTAL, 1, portal number passed to dpi_msgSource_beat.
MAX_WORDS, 16, capacity of the request payload buffer in 32-bit words.

Ports:
CLK  input  1  single clock; all logic and all DPI calls run on its rising edge.
RST_N  input  1  synchronous reset, active low; sampled on the rising edge of CLK.

Behaviour:
- Interface: one clock, CLK. Reset RST_N is synchronous and active-low.
- While RST_N=0 at a posedge:
  - FSM goes to RX_HDR.
  - Buffer, word counters, req_count and err_count are cleared to 0.
  - No DPI call is made.
- Message format: the first beat is the header.
  - Header bits [31:16] hold the method id.
  - Header bits [15:0] hold the total length in words, header included.
  - A length of 0 is treated as 1.
- Receive, states RX_HDR and RX_BODY: at each posedge in these states the shell calls dpi_msgSink_beat(REQ_PORTAL, beat, src_rdy) exactly once.
  - src_rdy=0: no beat is taken and the state is unchanged.
  - src_rdy!=0: the beat is consumed.
  - In RX_HDR, a consumed beat latches the method id and length.
    - Length 1 goes to PROCESS.
    - Any other length goes to RX_BODY.
  - In RX_BODY, a consumed beat is stored at buf[idx] only if idx<MAX_WORDS. Words beyond MAX_WORDS are consumed and discarded.
  - After length-1 payload beats, the FSM goes to PROCESS.
- PROCESS lasts one cycle with no DPI call. It builds the indication and goes to TX.
  - Method 0, say(v): indication header {16'd0,16'd2}, then v (buf[0]).
  - Method 1, say2(a,b): indication header {16'd1,16'd3}, then buf[0], then buf[1].
  - Method 2, ping: indication header {16'd2,16'd2}, then req_count after the increment.
  - Any other method:
    - err_count increments.
    - Indication header {16'd3,16'd3}, then {16'b0,method}, then {16'b0,length}.
  - Missing payload words, from a message shorter than its method needs, read as 0.
  - req_count increments, wrapping at 32 bits, for every message including errors.
- TX: one dpi_msgSource_beat(IND_PORTAL, beat) call per posedge, in beat order.
  - No sink polling during TX; this is the backpressure to the host.
  - After the last beat the FSM returns to RX_HDR.
  - The next sink poll happens on the following posedge.
- Latency: the last request beat is consumed at edge N. The indication header is emitted at edge N+2 and the following beats at N+3 and later.
- Throughput: one message in flight. Requests are never reordered, dropped, or duplicated, except in the reset case below.
- Reset mid-operation: a partially received or partially transmitted message is discarded. No further beats of it are emitted. Operation resumes in RX_HDR after RST_N returns to 1.
- No X propagates to DPI arguments; unused buffer words read as 0.

Test Plan:
- The host queues three beats during reset: {0,2} and 0x12345678 (a say message), then {2,1} (a ping). The harness deasserts reset after 20 cycles.
  - No sink poll occurs while in reset.
  - Out of reset, the source emits 0x00000002, 0x12345678, then 0x00020002, 0x00000002 (ping reports req_count=2).
- say2: host sends {1,3}, 0xAAAA0001, 0xBBBB0002.
  - Source emits 0x00010003, 0xAAAA0001, 0xBBBB0002.
  - The header is emitted exactly 2 edges after the last request beat.
- Host-stall pattern (src_rdy=0 on alternate polls during say2): beats are still consumed in order, and the indication is identical to the say2 case.
- Unknown method: host sends {7,4} plus 3 payload words.
  - Source emits 0x00030003, 0x00000007, 0x00000004.
  - The next say message echoes correctly.
- Oversize: host sends {0,20} plus 19 words.
  - Only words 0-15 are stored and the rest are consumed.
  - The echo returns word 0.
- Reset during TX: assert RST_N=0 after the header beat of a say2 echo.
  - No further source beats are emitted.
  - After release, a ping returns 0x00020002, 0x00000001.
